// File: rtl/key_code_sender.sv
// key_code_sender: serial key transmitter for the locker_moore detector.
// Latches a parallel code on start and shifts it out LSB-first, one bit per
// clock, with key_vld qualifying each bit. Every output is registered, so the
// outputs reflect the state the FSM was in one cycle earlier.
//
// Optional feature macro: KEY_CODE_SENDER_ACK_EN
//   defined   - after the last bit the sender waits up to TIMEOUT cycles for
//               unlock, retransmits up to MAX_RETRY times, and pulses fail
//               when retries run out.
//   undefined - done pulses right after the last bit; unlock is ignored and
//               fail is constant 0.
//
// Handshake: there is no ready signal. A request is accepted on any rising
// edge where start=1 and the FSM is in IDLE; start in any other state is
// dropped (no queueing). busy reports "not in IDLE" one cycle late, which is
// why start is accepted in the cycle where done/fail are shown with busy=0.
// dbg_state exposes the FSM state register for checkers.
module key_code_sender #(
   parameter int CODE_W    = 5,
   parameter int TIMEOUT   = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CODE_W-1:0] code,
   input  logic              unlock,
   output logic              key,
   output logic              key_vld,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [1:0]        dbg_state
);

   localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(CODE_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_q, bit_d;
   // Terminal events are decided on the FSM edge and shown one cycle later.
   logic              done_pend_q, done_pend_d;
   logic              key_q, key_vld_q, busy_q, done_q;

`ifdef KEY_CODE_SENDER_ACK_EN
   localparam logic [7:0] LAST_TMO  = 8'(TIMEOUT - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

   logic [CODE_W-1:0] code_reg_q, code_reg_d;
   logic [7:0]        tmo_q, tmo_d;
   logic [2:0]        retry_q, retry_d;
   logic              fail_pend_q, fail_pend_d;
   logic              fail_q;
`else
   logic              unused_unlock;
   assign unused_unlock = unlock;
`endif

   // Next-state logic: sequencing of IDLE -> SEND (-> WAIT) -> IDLE.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_d       = bit_q;
      done_pend_d = 1'b0;
`ifdef KEY_CODE_SENDER_ACK_EN
      code_reg_d  = code_reg_q;
      tmo_d       = tmo_q;
      retry_d     = retry_q;
      fail_pend_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d = code;
               bit_d   = '0;
               state_d = S_SEND;
`ifdef KEY_CODE_SENDER_ACK_EN
               code_reg_d = code;
               retry_d    = '0;
`endif
            end
         end
         S_SEND: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
               bit_d = '0;
`ifdef KEY_CODE_SENDER_ACK_EN
               tmo_d   = '0;
               state_d = S_WAIT;
`else
               state_d     = S_IDLE;
               done_pend_d = 1'b1;
`endif
            end
         end
`ifdef KEY_CODE_SENDER_ACK_EN
         S_WAIT: begin
            // unlock wins even on the final timeout edge.
            if (unlock) begin
               state_d     = S_IDLE;
               done_pend_d = 1'b1;
            end else if (tmo_q == LAST_TMO) begin
               tmo_d = '0;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  shift_d = code_reg_q;
                  bit_d   = '0;
                  state_d = S_SEND;
               end else begin
                  state_d     = S_IDLE;
                  fail_pend_d = 1'b1;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_q       <= '0;
         done_pend_q <= 1'b0;
`ifdef KEY_CODE_SENDER_ACK_EN
         code_reg_q  <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         fail_pend_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_q       <= bit_d;
         done_pend_q <= done_pend_d;
`ifdef KEY_CODE_SENDER_ACK_EN
         code_reg_q  <= code_reg_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         fail_pend_q <= fail_pend_d;
`endif
      end
   end

   // Output registers, decoded from the current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q     <= 1'b0;
         key_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef KEY_CODE_SENDER_ACK_EN
         fail_q    <= 1'b0;
`endif
      end else begin
         key_q     <= (state_q == S_SEND) & shift_q[0];
         key_vld_q <= (state_q == S_SEND);
         busy_q    <= (state_q != S_IDLE);
         done_q    <= done_pend_q;
`ifdef KEY_CODE_SENDER_ACK_EN
         fail_q    <= fail_pend_q;
`endif
      end
   end

   assign key       = key_q;
   assign key_vld   = key_vld_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;
`ifdef KEY_CODE_SENDER_ACK_EN
   assign fail      = fail_q;
`else
   assign fail      = 1'b0;
`endif

endmodule

// File: doc/key_code_sender.md
# key_code_sender

Serial key transmitter that drives the `locker_moore` sequence detector's `key` input. It latches a parallel code on a start request and shifts it out LSB-first, one bit per clock, with a qualifying valid strobe. It optionally waits for the locker's unlock indication and retransmits on timeout. It sits between the control/keypad logic and the locker, and is the stimulus source used on the locker's input side.

## Interface
Parameters:
- `CODE_W`, default 5: code length in bits; range 2–16.
- `TIMEOUT`, default 8: unlock wait window in cycles; range 1–255. Used only with the ack feature.
- `MAX_RETRY`, default 2: retransmissions after the first attempt; range 0–7. Used only with the ack feature.

Ports (reset is asynchronous and active-high):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to transmit `code`; sampled only in IDLE.
- `code` in CODE_W: key code; bit 0 is sent first.
- `unlock` in 1: locker `out`; used only with the ack feature.
- `key` out 1: serial key bit to the locker.
- `key_vld` out 1: high while `key` carries a code bit.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a transaction succeeds.
- `fail` out 1: one-cycle pulse when retries are exhausted. Tied 0 without the ack feature.

## Operation
- States: IDLE, SEND, WAIT. WAIT exists only with the ack feature.
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, and shift register, bit counter, timeout counter and retry counter are all 0.
- IDLE:
  - `start`=1 latches `code` into `code_reg` and into the shift register, clears the retry counter, and moves to SEND.
  - `key`=0, `key_vld`=0.
- SEND:
  - `key`=shift[0] and `key_vld`=1; the shift register shifts right each cycle.
  - The bit counter runs 0..CODE_W-1.
  - After the last bit:
    - Without ack: go to IDLE and pulse `done`.
    - With ack: go to WAIT with the timeout counter at 0.
- WAIT (ack only):
  - `key`=0, `key_vld`=0.
  - `unlock` sampled 1 on any edge in WAIT: go to IDLE and pulse `done`.
  - No `unlock` after TIMEOUT cycles, with retry counter < MAX_RETRY: increment the retry counter, reload the shift register from `code_reg`, and go to SEND.
  - No `unlock` after TIMEOUT cycles, with retries exhausted: go to IDLE and pulse `fail`.
- Boundary conditions:
  - `start` while `busy`=1 is ignored. There is no queueing, and `code` changes during a transaction have no effect.
  - `unlock` during SEND or IDLE is ignored.
  - `done`/`fail` are asserted in the first IDLE cycle, with `busy`=0. A `start` sampled in that cycle is accepted, giving back-to-back transactions with no gap cycle.
  - `rst` asserted mid-SEND or mid-WAIT forces all outputs to 0 immediately (asynchronous). No partial code or pulse follows reset release.
  - `done` and `fail` are never high together.

## Timing
- `start` is sampled high at edge k.
- Bit i appears on `key` (with `key_vld`=1) from edge k+1+i to edge k+2+i, for i=0..CODE_W-1.
- `busy`=1 from edge k+1 through the last SEND/WAIT cycle.
- Without ack: `done`=1 for exactly the cycle after edge k+1+CODE_W, with `key_vld`=0.
- With ack:
  - WAIT spans edges k+1+CODE_W through k+CODE_W+TIMEOUT.
  - `unlock` sampled at WAIT edge j gives `done` in the following cycle.
  - On a retry, bit 0 is resent in the cycle immediately after the last WAIT cycle.
- Worst-case transaction length with ack: (MAX_RETRY+1)·(CODE_W+TIMEOUT) cycles, plus 1 cycle for `fail`.

## Configuration
- Macro: `KEY_CODE_SENDER_ACK_EN`.
- Defined: the WAIT state, timeout counter, retry counter, `unlock` monitoring and `fail` are all compiled in.
- Undefined:
  - SEND transitions straight to IDLE and `done` pulses after the last bit.
  - `unlock` is unused and `fail` is constant 0.
  - TIMEOUT and MAX_RETRY have no effect.

## Test plan
- Basic send, no ack, CODE_W=5: `code`=5'b01011 and `start` at edge k -> `key`=1,1,0,1,0 on cycles k+1..k+5 with `key_vld`=1, then `done`=1 for one cycle, with `busy`=0 and `key`=0.
- Busy lockout: `start` with `code`=5'b01011, then `start` with `code`=5'b11111 at k+2 -> serial stream unchanged, single `done`, no second transaction.
- Back-to-back: `start` held high -> second code's bit 0 appears the cycle after `done`, with no gap cycle.
- Reset mid-transaction: `rst` high for one cycle after bit 2 -> `key`, `key_vld`, `busy`, `done` go to 0 immediately and stay 0 after release until the next `start`.
- Ack success, ACK_EN, TIMEOUT=4: the real `locker_moore` is connected and `code`=5'b01011 -> locker `out` rises, `done` pulses within 4 cycles of the last bit, `fail`=0.
- Ack failure, ACK_EN, TIMEOUT=4, MAX_RETRY=2: `unlock` tied 0 -> exactly 3 full transmissions separated by 4 idle-key cycles, then `fail`=1 for one cycle and `done` stays 0.
